// File: rtl/snn_lif_layer_if.sv
// Input-vector / spike-output bundle for the LIF spiking layer.
// Ports: i_valid/o_ready/i_data carry one input vector per handshake;
//        o_valid/o_spike/o_count report the result of each layer step.
interface snn_lif_layer_if #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 3,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic                     i_valid;
    logic                     o_ready;
    logic [N_IN*DATA_W-1:0]   i_data;
    logic                     o_valid;
    logic [N_OUT-1:0]         o_spike;
    logic [N_OUT*CNT_W-1:0]   o_count;

    // producer side (encoder / testbench)
    modport master (output i_valid, i_data, input o_ready, o_valid, o_spike, o_count);
    // layer side
    modport slave  (input i_valid, i_data, output o_ready, o_valid, o_spike, o_count);
endinterface

// File: rtl/snn_lif_layer.sv
// Leaky-integrate-and-fire layer: N_IN inputs MAC'd one channel per cycle into N_OUT neurons.
// Latency: accept on edge E, MACs on E+1..E+N_IN, membrane update + o_valid pulse after E+N_IN+1.
// Backpressure: o_ready only in IDLE; no input buffering, producer holds the vector until accepted.
// Ports: i_clk/i_rstn plain; io_bus (slave) carries handshake + spike outputs; weight write port,
//        i_threshold, i_leak_shift and i_clr_cnt are plain configuration inputs.
module snn_lif_layer #(
    parameter int N_IN     = 3,
    parameter int N_OUT    = 3,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int POT_W    = 16,
    parameter int REFRAC   = 2,
    parameter int CNT_W    = 8,
    localparam int AW      = (N_IN*N_OUT > 1) ? $clog2(N_IN*N_OUT) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    snn_lif_layer_if.slave             io_bus,
    input  logic                       i_wr_en,
    input  logic [AW-1:0]              i_wr_addr,
    input  logic signed [WEIGHT_W-1:0] i_wr_data,
    input  logic signed [POT_W-1:0]    i_threshold,
    input  logic [3:0]                 i_leak_shift,
    input  logic                       i_clr_cnt
);
    localparam int PROD_W = DATA_W + WEIGHT_W + 1;
    // two guard bits above the widest operand so v - leak + acc never wraps before saturation
    localparam int SUM_W  = ((POT_W > PROD_W) ? POT_W : PROD_W) + 2;
    localparam int KW     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int RW     = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-POT_W+1){1'b0}}, {(POT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-POT_W+1){1'b1}}, {(POT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FIRE} state_t;

    state_t                     r_state, w_state_nxt;
    logic [DATA_W-1:0]          r_x   [N_IN];
    logic [KW-1:0]              r_k;
    logic signed [WEIGHT_W-1:0] r_w   [N_OUT][N_IN];
    logic signed [POT_W-1:0]    r_acc [N_OUT];
    logic signed [POT_W-1:0]    r_v   [N_OUT];
    logic [RW-1:0]              r_ref [N_OUT];
    logic [CNT_W-1:0]           r_cnt [N_OUT];
    logic [N_OUT-1:0]           r_spike;
    logic                       r_valid;

    logic signed [PROD_W-1:0]   w_prod    [N_OUT];
    logic signed [POT_W-1:0]    w_acc_nxt [N_OUT];
    logic signed [POT_W-1:0]    w_t       [N_OUT];
    logic [N_OUT-1:0]           w_spk;
    logic                       w_wr_ok;
    logic                       w_last_k;

    function automatic logic signed [SUM_W-1:0] f_sx_pot(input logic signed [POT_W-1:0] a);
        return {{(SUM_W-POT_W){a[POT_W-1]}}, a};
    endfunction

    function automatic logic signed [SUM_W-1:0] f_sx_prod(input logic signed [PROD_W-1:0] a);
        return {{(SUM_W-PROD_W){a[PROD_W-1]}}, a};
    endfunction

    function automatic logic signed [POT_W-1:0] f_sat(input logic signed [SUM_W-1:0] x);
        if (x > SAT_MAX)      return SAT_MAX[POT_W-1:0];
        else if (x < SAT_MIN) return SAT_MIN[POT_W-1:0];
        else                  return x[POT_W-1:0];
    endfunction

    // t = v - (v >>> shift) + acc; shift 0 means no leak (not "subtract all of v")
    function automatic logic signed [POT_W-1:0] f_update(input logic signed [POT_W-1:0] v,
                                                         input logic signed [POT_W-1:0] acc,
                                                         input logic [3:0]              sh);
        logic signed [SUM_W-1:0] vs;
        logic signed [SUM_W-1:0] lk;
        vs = f_sx_pot(v);
        if (sh != 4'd0) lk = vs >>> sh;
        else            lk = '0;
        return f_sat(vs - lk + f_sx_pot(acc));
    endfunction

    assign w_last_k = (r_k == KW'(N_IN - 1));
    assign w_wr_ok  = i_wr_en && (r_state == S_IDLE) &&
                      ({{(32-AW){1'b0}}, i_wr_addr} < 32'(N_IN*N_OUT));

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            w_prod[j]    = $signed({{(PROD_W-WEIGHT_W){r_w[j][r_k][WEIGHT_W-1]}}, r_w[j][r_k]}) *
                           $signed({{(PROD_W-DATA_W){1'b0}}, r_x[r_k]});
            w_acc_nxt[j] = f_sat(f_sx_pot(r_acc[j]) + f_sx_prod(w_prod[j]));
            w_t[j]       = f_update(r_v[j], r_acc[j], i_leak_shift);
            w_spk[j]     = (r_ref[j] == '0) && (w_t[j] >= i_threshold);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (io_bus.i_valid) w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_last_k)       w_state_nxt = S_FIRE;
            S_FIRE:                      w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_k     <= '0;
            r_spike <= '0;
            r_valid <= 1'b0;
            for (int k = 0; k < N_IN; k++) r_x[k] <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                r_acc[j] <= '0;
                r_v[j]   <= '0;
                r_ref[j] <= '0;
                r_cnt[j] <= '0;
                for (int k = 0; k < N_IN; k++) r_w[j][k] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.i_valid) begin
                        for (int k = 0; k < N_IN; k++) r_x[k] <= io_bus.i_data[k*DATA_W +: DATA_W];
                        for (int j = 0; j < N_OUT; j++) r_acc[j] <= '0;
                        r_k <= '0;
                    end
                end
                S_ACCUM: begin
                    for (int j = 0; j < N_OUT; j++) r_acc[j] <= w_acc_nxt[j];
                    r_k <= r_k + KW'(1);
                end
                S_FIRE: begin
                    r_valid <= 1'b1;
                    r_spike <= w_spk;
                    for (int j = 0; j < N_OUT; j++) begin
                        if (r_ref[j] != '0) begin
                            r_v[j]   <= '0;
                            r_ref[j] <= r_ref[j] - RW'(1);
                        end else if (w_spk[j]) begin
                            r_v[j]   <= '0;
                            r_ref[j] <= RW'(REFRAC);
                        end else begin
                            r_v[j]   <= w_t[j];
                        end
                    end
                end
                default: ;
            endcase

            if (w_wr_ok) begin
                for (int j = 0; j < N_OUT; j++)
                    for (int k = 0; k < N_IN; k++)
                        if (i_wr_addr == AW'(j*N_IN + k)) r_w[j][k] <= i_wr_data;
            end

            // clear has priority over a coincident increment
            for (int j = 0; j < N_OUT; j++) begin
                if (i_clr_cnt)
                    r_cnt[j] <= '0;
                else if ((r_state == S_FIRE) && w_spk[j] && (r_cnt[j] != '1))
                    r_cnt[j] <= r_cnt[j] + CNT_W'(1);
            end
        end
    end

    assign io_bus.o_ready = (r_state == S_IDLE);
    assign io_bus.o_valid = r_valid;
    assign io_bus.o_spike = r_spike;

    always_comb begin
        io_bus.o_count = '0;
        for (int j = 0; j < N_OUT; j++) io_bus.o_count[j*CNT_W +: CNT_W] = r_cnt[j];
    end
endmodule

// File: tb/tb_snn_lif_layer.sv
module tb_snn_lif_layer;
    localparam int N_IN = 3, N_OUT = 3, DATA_W = 8, WEIGHT_W = 8, POT_W = 16, REFRAC = 2, CNT_W = 8;
    localparam int AW = 4;

    logic                       i_clk = 1'b0;
    logic                       i_rstn = 1'b0;
    logic                       i_wr_en = 1'b0;
    logic [AW-1:0]              i_wr_addr = '0;
    logic signed [WEIGHT_W-1:0] i_wr_data = '0;
    logic signed [POT_W-1:0]    i_threshold = '0;
    logic [3:0]                 i_leak_shift = '0;
    logic                       i_clr_cnt = 1'b0;

    snn_lif_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    snn_lif_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W),
                    .POT_W(POT_W), .REFRAC(REFRAC), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .io_bus(bus),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_threshold(i_threshold), .i_leak_shift(i_leak_shift), .i_clr_cnt(i_clr_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [N_OUT-1:0]       sp;
        logic [N_OUT*CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int m_w[N_OUT][N_IN];
    int m_v[N_OUT];
    int m_ref[N_OUT];
    int m_cnt[N_OUT];
    int m_thr;
    int m_leak;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_clear();
        for (int j = 0; j < N_OUT; j++) begin
            m_v[j] = 0; m_ref[j] = 0; m_cnt[j] = 0;
            for (int k = 0; k < N_IN; k++) m_w[j][k] = 0;
        end
    endtask

    task automatic model_step(input int x0, input int x1, input int x2, input bit clr, output exp_t e);
        int x[N_IN];
        int acc, t;
        bit s;
        x[0] = x0; x[1] = x1; x[2] = x2;
        e = '0;
        for (int j = 0; j < N_OUT; j++) begin
            acc = 0;
            for (int k = 0; k < N_IN; k++) acc = sat16(acc + m_w[j][k] * x[k]);
            s = 1'b0;
            if (m_ref[j] > 0) begin
                m_v[j] = 0;
                m_ref[j]--;
            end else begin
                t = sat16(m_v[j] - ((m_leak != 0) ? (m_v[j] >>> m_leak) : 0) + acc);
                if (t >= m_thr) begin
                    s = 1'b1; m_v[j] = 0; m_ref[j] = REFRAC;
                end else begin
                    m_v[j] = t;
                end
            end
            if (clr)                      m_cnt[j] = 0;
            else if (s && m_cnt[j] < 255) m_cnt[j]++;
            e.sp[j] = s;
            e.cnt[j*CNT_W +: CNT_W] = CNT_W'(m_cnt[j]);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        bus.i_valid = 1'b0; i_wr_en = 1'b0; i_clr_cnt = 1'b0;
        i_rstn = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        model_clear();
        sb_q.delete();
    endtask

    task automatic set_cfg(input int thr, input int leak);
        m_thr = thr; m_leak = leak;
        i_threshold = POT_W'(thr);
        i_leak_shift = 4'(leak);
    endtask

    task automatic wr_w(input int addr, input int data);
        @(negedge i_clk);
        i_wr_en = 1'b1; i_wr_addr = AW'(addr); i_wr_data = WEIGHT_W'(data);
        @(negedge i_clk);
        i_wr_en = 1'b0;
        if (addr < N_IN*N_OUT) m_w[addr / N_IN][addr % N_IN] = data;
    endtask

    task automatic set_all_w(input int data);
        for (int a = 0; a < N_IN*N_OUT; a++) wr_w(a, data);
    endtask

    // mode 0: plain step; 1: weight write to neuron1/input0 during ACCUM; 2: i_clr_cnt at the FIRE edge
    task automatic run_vec(input int x0, input int x1, input int x2, input int mode);
        exp_t e;
        int   lat;
        model_step(x0, x1, x2, (mode == 2), e);
        sb_q.push_back(e);
        @(negedge i_clk);
        chk("ready_idle", 64'(bus.o_ready), 64'd1);
        bus.i_valid = 1'b1;
        bus.i_data = {8'(x2), 8'(x1), 8'(x0)};
        @(posedge i_clk);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        chk("ready_busy", 64'(bus.o_ready), 64'd0);
        lat = 1;
        while (lat <= 20) begin
            if (lat > 1) @(negedge i_clk);
            if (mode == 1) begin
                i_wr_en = (lat == 1); i_wr_addr = AW'(3); i_wr_data = 8'sd5;
            end
            if (mode == 2) i_clr_cnt = (lat == N_IN + 1);
            if (bus.o_valid) break;
            lat++;
        end
        i_wr_en = 1'b0; i_clr_cnt = 1'b0;
        chk("latency", 64'(lat), 64'(N_IN + 2));
        e = sb_q.pop_front();
        chk("spike", 64'(bus.o_spike), 64'(e.sp));
        chk("count", 64'(bus.o_count), 64'(e.cnt));
        chk("ready_after", 64'(bus.o_ready), 64'd1);
        @(negedge i_clk);
        chk("valid_pulse", 64'(bus.o_valid), 64'd0);
    endtask

    initial begin
        bit seen;
        bus.i_valid = 1'b0;
        bus.i_data = '0;
        model_clear();
        set_cfg(0, 0);

        // reset values
        repeat (2) @(negedge i_clk);
        chk("rst_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_spike", 64'(bus.o_spike), 64'd0);
        chk("rst_count", 64'(bus.o_count), 64'd0);
        i_rstn = 1'b1;

        // integrate, no leak: 6 then 12 >= 10
        set_all_w(1);
        set_cfg(10, 0);
        run_vec(1, 2, 3, 0);
        chk("int_spike0", 64'(bus.o_spike), 64'd0);
        run_vec(1, 2, 3, 0);
        chk("int_spike1", 64'(bus.o_spike), 64'h7);
        chk("int_count1", 64'(bus.o_count), 64'h010101);

        // asynchronous reset in the middle of ACCUM
        @(negedge i_clk);
        bus.i_valid = 1'b1; bus.i_data = {8'd3, 8'd2, 8'd1};
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        @(negedge i_clk);
        #2 i_rstn = 1'b0;
        #1;
        chk("arst_ready", 64'(bus.o_ready), 64'd1);
        chk("arst_valid", 64'(bus.o_valid), 64'd0);
        chk("arst_spike", 64'(bus.o_spike), 64'd0);
        chk("arst_count", 64'(bus.o_count), 64'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        model_clear();
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (bus.o_valid) seen = 1'b1;
        end
        chk("arst_no_valid", 64'(seen), 64'd0);

        // leak: 60, 90, 105 -> spike
        do_reset();
        set_all_w(1);
        set_cfg(100, 1);
        run_vec(10, 20, 30, 0);
        run_vec(10, 20, 30, 0);
        chk("leak_nospike", 64'(bus.o_spike), 64'd0);
        run_vec(10, 20, 30, 0);
        chk("leak_spike", 64'(bus.o_spike), 64'h7);

        // refractory: 111, 000, 000, 111
        do_reset();
        set_all_w(1);
        set_cfg(1, 0);
        for (int s = 0; s < 4; s++) run_vec(40, 40, 40, 0);
        chk("refrac_count", 64'(bus.o_count), 64'h020202);

        // signed weight and negative saturation
        do_reset();
        wr_w(0, -128);
        set_cfg(100, 0);
        for (int s = 0; s < 3; s++) run_vec(255, 0, 0, 0);
        chk("sat_nospike", 64'(bus.o_spike), 64'd0);

        // write while busy is dropped; same write in IDLE takes effect; out-of-range address ignored
        do_reset();
        set_all_w(1);
        set_cfg(30, 0);
        run_vec(10, 0, 0, 1);
        chk("busy_wr_nospike", 64'(bus.o_spike), 64'd0);
        wr_w(3, 5);
        wr_w(12, 127);
        run_vec(10, 0, 0, 0);
        chk("idle_wr_spike", 64'(bus.o_spike), 64'h2);

        // counter saturation then clear coinciding with a spike
        do_reset();
        set_all_w(1);
        set_cfg(1, 0);
        for (int s = 0; s < 766; s++) run_vec(40, 40, 40, 0);
        chk("cnt_sat", 64'(bus.o_count), 64'hffffff);
        run_vec(40, 40, 40, 0);
        run_vec(40, 40, 40, 0);
        run_vec(40, 40, 40, 2);
        chk("clr_spike", 64'(bus.o_spike), 64'h7);
        chk("clr_count", 64'(bus.o_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
